alu_arbiter: RTL and testbench

- Shares one combinational ALU (3-bit opcode, DATA_WIDTH operands) between two requesters using round-robin arbitration.
- Accepts an operation over a valid/ready request channel, registers the operands, evaluates it, and returns a registered result on that requester's own valid/ready response channel.
- Sits between the CPU control unit (port 0) and a secondary engine such as a debug/DMA unit (port 1).
- One operation is in flight at a time.

---
 rtl/alu_arbiter_pkg.sv | 33 +++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter_alu.sv | 35 +++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode values, FSM states
// and the round-robin grant rule.
package alu_arbiter_pkg;

  localparam logic [2:0] OC_ADD = 3'd0;
  localparam logic [2:0] OC_SUB = 3'd1;
  localparam logic [2:0] OC_MUL = 3'd2;
  localparam logic [2:0] OC_DIV = 3'd3;
  localparam logic [2:0] OC_NOT = 3'd4;
  localparam logic [2:0] OC_XOR = 3'd5;
  localparam logic [2:0] OC_OR  = 3'd6;
  localparam logic [2:0] OC_AND = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // On a tie the port that did not win last time is chosen.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    logic g;
    if (v0 && v1) begin
      g = ~last;
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both ALU arbiter ports, grouped as one bundle.
interface alu_arbiter_if #(parameter int DATA_WIDTH = 16);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [2:0]            req0_oc;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [2:0]            req1_oc;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic                  rsp0_err;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_data;
  logic                  rsp1_err;

  modport master (
    output req0_valid, req0_oc, req0_a, req0_b,
    output req1_valid, req1_oc, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_oc, req0_a, req0_b,
    input  req1_valid, req1_oc, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both arbiter ports; results wrap to DATA_WIDTH.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  // Opcode decode; a zero divisor yields 0 here and is flagged by the caller
  always_comb begin
    y = {DATA_WIDTH{1'b0}};
    case (oc)
      OC_ADD: y = a + b;
      OC_SUB: y = a - b;
      OC_MUL: y = a * b;
      OC_DIV: begin
        if (b != {DATA_WIDTH{1'b0}}) begin
          y = a / b;
        end else begin
          y = {DATA_WIDTH{1'b0}};
        end
      end
      OC_NOT: y = ~a;
      OC_XOR: y = a ^ b;
      OC_OR:  y = a | b;
      OC_AND: y = a & b;
      default: y = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation
// in flight; IDLE accepts, EXEC evaluates for one cycle, RESP waits for the owner.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_t                     state_r;
  state_t                     state_next_s;
  logic                       last_grant_r;
  logic                       owner_r;
  logic [2:0]                 oc_r;
  logic [DATA_WIDTH-1:0]      a_r;
  logic [DATA_WIDTH-1:0]      b_r;
  logic [1:0]                 rsp_valid_r;
  logic [1:0][DATA_WIDTH-1:0] rsp_data_r;
  logic [1:0]                 rsp_err_r;

  logic                  grant_s;
  logic                  accept_s;
  logic                  release_s;
  logic [1:0]            req_ready_s;
  logic [1:0]            rsp_ready_s;
  logic [2:0]            req_oc_s;
  logic [DATA_WIDTH-1:0] req_a_s;
  logic [DATA_WIDTH-1:0] req_b_s;
  logic [DATA_WIDTH-1:0] alu_y_s;
  logic [DATA_WIDTH-1:0] result_s;
  logic                  div_zero_s;

  alu_arbiter_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .oc (oc_r),
    .a  (a_r),
    .b  (b_r),
    .y  (alu_y_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Arbitration, request ready and next-state decode
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = 2'b00;
    accept_s     = 1'b0;
    release_s    = 1'b0;
    rsp_ready_s  = {bus.rsp1_ready, bus.rsp0_ready};
    grant_s      = pick_grant(bus.req0_valid, bus.req1_valid, last_grant_r);
    case (state_r)
      ST_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          req_ready_s  = grant_s ? 2'b10 : 2'b01;
          accept_s     = 1'b1;
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_s[owner_r]) begin
          release_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Payload of the granted port and the divide-by-zero override
  always_comb begin
    req_oc_s   = grant_s ? bus.req1_oc : bus.req0_oc;
    req_a_s    = grant_s ? bus.req1_a  : bus.req0_a;
    req_b_s    = grant_s ? bus.req1_b  : bus.req0_b;
    div_zero_s = (oc_r == OC_DIV) && (b_r == {DATA_WIDTH{1'b0}});
    if (div_zero_s) begin
      result_s = {DATA_WIDTH{1'b1}};
    end else begin
      result_s = alu_y_s;
    end
  end

  // Operand capture and per-port response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      oc_r         <= 3'd0;
      a_r          <= {DATA_WIDTH{1'b0}};
      b_r          <= {DATA_WIDTH{1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_data_r   <= {(2*DATA_WIDTH){1'b0}};
      rsp_err_r    <= 2'b00;
    end else begin
      if (accept_s) begin
        oc_r         <= req_oc_s;
        a_r          <= req_a_s;
        b_r          <= req_b_s;
        owner_r      <= grant_s;
        last_grant_r <= grant_s;
      end
      if (state_r == ST_EXEC) begin
        rsp_data_r[owner_r]  <= result_s;
        rsp_err_r[owner_r]   <= div_zero_s;
        rsp_valid_r[owner_r] <= 1'b1;
      end
      if (release_s) begin
        rsp_valid_r[owner_r] <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = req_ready_s[0];
  assign bus.req1_ready = req_ready_s[1];
  assign bus.rsp0_valid = rsp_valid_r[0];
  assign bus.rsp1_valid = rsp_valid_r[1];
  assign bus.rsp0_data  = rsp_data_r[0];
  assign bus.rsp1_data  = rsp_data_r[1];
  assign bus.rsp0_err   = rsp_err_r[0];
  assign bus.rsp1_err   = rsp_err_r[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a random phase,
// compared every cycle against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int DW = 16;

  typedef struct packed {
    logic [2:0]    oc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  alu_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  op_t q0[$];
  op_t q1[$];
  int  obs_grants[$];

  bit            inflight;
  int            age;
  int            m_owner;
  int            m_last;
  logic [DW-1:0] exp_data [2];
  logic          exp_err  [2];
  logic [DW-1:0] cur_data;
  logic          cur_err;

  function automatic op_t mk(input logic [2:0] oc, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_t o;
    o.oc = oc;
    o.a  = a;
    o.b  = b;
    return o;
  endfunction

  // Reference arithmetic on wide unsigned integers, reduced modulo 2^16.
  function automatic logic [DW:0] ref_op(input op_t o);
    int unsigned x;
    int unsigned y;
    int unsigned r;
    logic        e;
    x = 32'(o.a);
    y = 32'(o.b);
    e = 1'b0;
    r = 32'd0;
    case (o.oc)
      3'd0: r = x + y;
      3'd1: r = x + 32'd65536 - y;
      3'd2: r = x * y;
      3'd3: begin
        if (y == 32'd0) begin
          r = 32'd65535;
          e = 1'b1;
        end else begin
          r = x / y;
        end
      end
      3'd4: r = 32'd65535 - x;
      3'd5: r = x ^ y;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    r = r % 32'd65536;
    return {e, r[DW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    if (q0.size() > 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_oc    = q0[0].oc;
      bus.req0_a     = q0[0].a;
      bus.req0_b     = q0[0].b;
    end else begin
      bus.req0_valid = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.req1_valid = 1'b1;
      bus.req1_oc    = q1[0].oc;
      bus.req1_a     = q1[0].a;
      bus.req1_b     = q1[0].b;
    end else begin
      bus.req1_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    inflight    = 1'b0;
    age         = 0;
    m_owner     = 0;
    m_last      = 1;
    exp_data[0] = '0;
    exp_data[1] = '0;
    exp_err[0]  = 1'b0;
    exp_err[1]  = 1'b0;
  endtask

  // One clock: check readies before the edge, advance the model, check responses after.
  task automatic step();
    int       g;
    bit [1:0] rr;
    op_t      o;
    logic [DW:0] res;
    #1;
    g = -1;
    if (!inflight) begin
      if (bus.req0_valid && bus.req1_valid) g = (m_last == 1) ? 0 : 1;
      else if (bus.req0_valid) g = 0;
      else if (bus.req1_valid) g = 1;
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
    if (bus.req0_ready === 1'b1) obs_grants.push_back(0);
    else if (bus.req1_ready === 1'b1) obs_grants.push_back(1);
    rr = {bus.rsp1_ready, bus.rsp0_ready};
    @(posedge clk);
    #1;
    if (inflight) begin
      if (age >= 1 && rr[m_owner]) inflight = 1'b0;
      else age++;
    end else if (g >= 0) begin
      if (g == 0) o = q0.pop_front();
      else        o = q1.pop_front();
      res      = ref_op(o);
      cur_err  = res[DW];
      cur_data = res[DW-1:0];
      inflight = 1'b1;
      age      = 0;
      m_owner  = g;
      m_last   = g;
    end
    for (int p = 0; p < 2; p++) begin
      if (inflight && age >= 1 && m_owner == p) begin
        exp_data[p] = cur_data;
        exp_err[p]  = cur_err;
      end
    end
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(inflight && age >= 1 && m_owner == 0));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(inflight && age >= 1 && m_owner == 1));
    chk("rsp0_data",  32'(bus.rsp0_data),  32'(exp_data[0]));
    chk("rsp1_data",  32'(bus.rsp1_data),  32'(exp_data[1]));
    chk("rsp0_err",   32'(bus.rsp0_err),   32'(exp_err[0]));
    chk("rsp1_err",   32'(bus.rsp1_err),   32'(exp_err[1]));
    present();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || inflight) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    present();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("rst_rsp0_data",  32'(bus.rsp0_data),  32'd0);
    chk("rst_rsp1_data",  32'(bus.rsp1_data),  32'd0);
    chk("rst_rsp_err",    32'({bus.rsp1_err, bus.rsp0_err}), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_oc = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_oc = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    model_reset();

    // Single request on port 0
    do_reset();
    q0.push_back(mk(3'd0, 16'd5, 16'd7));
    present();
    drain("single", 20);
    chk("single_data", 32'(bus.rsp0_data), 32'd12);

    // Simultaneous requests after reset: port 0 first
    do_reset();
    obs_grants.delete();
    q0.push_back(mk(3'd1, 16'd10, 16'd3));
    q1.push_back(mk(3'd2, 16'd300, 16'd300));
    present();
    drain("simul", 30);
    chk("simul_first",  32'(obs_grants[0]), 32'd0);
    chk("simul_second", 32'(obs_grants[1]), 32'd1);
    chk("simul_sub",    32'(bus.rsp0_data), 32'd7);
    chk("simul_mul",    32'(bus.rsp1_data), 32'h5F90);

    // Divide by zero, then a normal divide
    q1.push_back(mk(3'd3, 16'd100, 16'd0));
    q1.push_back(mk(3'd3, 16'd100, 16'd7));
    present();
    drain("div", 30);
    chk("div_data", 32'(bus.rsp1_data), 32'd14);
    chk("div_err",  32'(bus.rsp1_err),  32'd0);

    // Backpressure on port 0 with port 1 waiting
    obs_grants.delete();
    bus.rsp0_ready = 1'b0;
    q0.push_back(mk(3'd5, 16'h1234, 16'h00FF));
    q1.push_back(mk(3'd6, 16'h0F00, 16'h00F0));
    present();
    repeat (7) step();
    bus.rsp0_ready = 1'b1;
    drain("bp", 30);
    chk("bp_grants", 32'(obs_grants.size()), 32'd2);
    chk("bp_order",  32'(obs_grants[1]), 32'd1);

    // Continuous contention: strict alternation
    obs_grants.delete();
    q0.push_back(mk(3'd4, 16'h00FF, 16'h0000));
    q0.push_back(mk(3'd6, 16'hA0A0, 16'h0505));
    q0.push_back(mk(3'd5, 16'hFFFF, 16'h1234));
    q1.push_back(mk(3'd5, 16'hF0F0, 16'h0FF0));
    q1.push_back(mk(3'd7, 16'hABCD, 16'h0FF0));
    q1.push_back(mk(3'd0, 16'hFFFF, 16'h0002));
    present();
    drain("cont", 60);
    chk("cont_grants", 32'(obs_grants.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("cont_order", 32'(obs_grants[i]), 32'(i % 2));

    // Reset while an operation is in EXEC
    q1.push_back(mk(3'd0, 16'd1, 16'd1));
    present();
    step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    q0.delete();
    q1.delete();
    present();
    chk("rstx_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    repeat (4) step();
    obs_grants.delete();
    q0.push_back(mk(3'd2, 16'd3, 16'd4));
    q1.push_back(mk(3'd1, 16'd0, 16'd1));
    present();
    drain("rstx", 30);
    chk("rstx_tie", 32'(obs_grants[0]), 32'd0);

    // Random traffic with random backpressure and withdrawals
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0)
        q0.push_back(mk(3'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom)));
      if (q1.size() == 0 && $urandom_range(0, 2) == 0)
        q1.push_back(mk(3'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom)));
      if (q0.size() > 0 && $urandom_range(0, 15) == 0) void'(q0.pop_front());
      if (q1.size() > 0 && $urandom_range(0, 15) == 0) void'(q1.pop_front());
      bus.rsp0_ready = 1'($urandom_range(0, 1));
      bus.rsp1_ready = 1'($urandom_range(0, 1));
      present();
      step();
    end
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drain("rand", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
